// File: rtl/arb_pkg.sv
// arb_pkg: shared types, sizes and helpers for the round-robin arbiter
package arb_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational search for the first set request starting at ptr, wrapping modulo 4
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [1:0]           off;
  // rotate so that bit 0 is the requester at ptr, then find the nearest set bit
  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[NUM_REQ-1:0];
    off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    idx_o   = ptr_i + off;
    found_o = |req_i;
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with hold timeout and registered any-request flag
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [1:0]         gnt_id,
  output logic               any_req,
  output logic               timeout
);
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);
  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d, id_q, id_d, pick_idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d, any_q, to_q, to_d, pick_found, at_max, rel;
  rr_pick_4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );
  // next state: grant from IDLE, release on done/withdrawal/hold limit, otherwise count
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    at_max  = cnt_q == CNT_LAST;
    rel     = done | ~req[id_q] | at_max;
    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d = GRANT;
        id_d    = pick_idx;
        gnt_d   = to_onehot(pick_idx);
        vld_d   = 1'b1;
        cnt_d   = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      vld_d   = 1'b0;
      ptr_d   = id_q + 2'd1;
      to_d    = at_max & ~done;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  // state and output registers; reset clears everything, so a reset mid-grant never pulses timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      any_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      any_q   <= |req;
      to_q    <= to_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id    = id_q;
  assign any_req   = any_q;
  assign timeout   = to_q;
endmodule
